// File: rtl/prco_fetch_pkg.sv
// rtl/prco_fetch_pkg.sv - state encodings and reset constants for prco_fetch
package prco_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] PRCO_RESET_PC = 16'h0000;

endpackage

// File: rtl/prco_fetch.sv
// rtl/prco_fetch.sv - instruction fetch unit: one memory read per decoder request, PC redirect with drain
module prco_fetch
  import prco_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = PRCO_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_fetch,
  input  logic        i_branch,
  input  logic [15:0] i_branch_addr,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data,
  output logic [15:0] q_instr,
  output logic        q_ce,
  output logic [15:0] q_pc,
  output logic        q_busy
);

  fetch_state_e state, state_nx;
  logic [15:0]  pc, pc_nx;
  logic [15:0]  drain_addr;
  logic         pending, pending_nx;
  logic         issue;

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pending_nx = pending;
    issue      = 1'b0;
    // a redirect always lands in pc; only the state reaction differs
    if (i_branch) pc_nx = i_branch_addr;
    case (state)
      ST_IDLE: begin
        if (i_en) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_mem_ack) begin
          if (!i_branch) begin
            issue    = 1'b1;
            pc_nx    = pc + 16'd1;
            state_nx = ST_WAIT;
          end
        end else if (i_branch) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_mem_ack) state_nx = ST_FETCH;
      end
      ST_WAIT: begin
        if ((i_fetch || pending) && i_en) begin
          state_nx   = ST_FETCH;
          pending_nx = 1'b0;
        end else begin
          pending_nx = pending | i_fetch;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      pending    <= 1'b0;
      drain_addr <= 16'h0000;
      q_ce       <= 1'b0;
      q_instr    <= 16'h0000;
      q_pc       <= 16'h0000;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      pending <= pending_nx;
      q_ce    <= issue;
      if (issue) begin
        q_instr <= i_mem_data;
        q_pc    <= pc;
      end
      // the abandoned read keeps its address on the bus while pc moves on
      if (state == ST_FETCH && i_branch && !i_mem_ack) drain_addr <= pc;
    end
  end

  assign o_mem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign o_mem_addr = (state == ST_FETCH) ? pc :
                      (state == ST_DRAIN) ? drain_addr : 16'h0000;
  assign q_busy     = o_mem_req;

endmodule
